// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage and its consumers.
// The IF/ID bundle layout is reused by the decode stage, so keep it stable.
package instruction_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    // Encoding that stops fetch, and the bubble placed in IF/ID on flush/reset.
    localparam logic [XLEN-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] NOP_WORD_DEFAULT  = 32'h0000_0000;

    // Byte increment between sequential instruction words.
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    // IF/ID pipeline register contents handed to decode.
    typedef struct packed {
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] pcplus4;
        logic            valid;
    } if_id_t;

    // Word-align a byte address by clearing its two low bits.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Signals between the fetch unit (master) and its environment: hazard and
// branch control coming in, instruction memory port, IF/ID bundle going out.
interface instruction_fetch_unit_if;
    import instruction_fetch_unit_pkg::*;

    // Control from hazard / branch resolution
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;

    // Instruction memory port (combinational read)
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] instruction;

    // IF/ID pipeline register and status
    logic [XLEN-1:0] if_id_instruction;
    logic [XLEN-1:0] if_id_pcplus4;
    logic            if_id_valid;
    logic            halted;
    logic            misaligned;

    modport master (
        input  stall,
        input  redirect_valid,
        input  redirect_target,
        input  instruction,
        output address,
        output if_id_instruction,
        output if_id_pcplus4,
        output if_id_valid,
        output halted,
        output misaligned
    );

    modport slave (
        output stall,
        output redirect_valid,
        output redirect_target,
        output instruction,
        input  address,
        input  if_id_instruction,
        input  if_id_pcplus4,
        input  if_id_valid,
        input  halted,
        input  misaligned
    );

endinterface

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register: flush has priority over load, otherwise hold.
module instruction_fetch_unit_if_id_register
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_flush,
    input  logic   i_load,
    input  if_id_t i_d,
    output if_id_t o_q
);

    if_id_t r_q;

    // Flush inserts a bubble, load captures the new bundle, otherwise hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '{instruction: NOP_WORD, pcplus4: '0, valid: 1'b0};
        end else if (i_flush) begin
            r_q <= '{instruction: NOP_WORD, pcplus4: '0, valid: 1'b0};
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction memory address,
// and fills the IF/ID register. Handles stall, redirect-with-flush, and a
// halt state entered when the sentinel word is fetched.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] HALT_WORD = HALT_WORD_DEFAULT,
    parameter logic [XLEN-1:0] NOP_WORD  = NOP_WORD_DEFAULT
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    instruction_fetch_unit_if.master   bus
);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_halted;
    logic            r_misaligned;

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_redirect;
    logic            w_target_misaligned;
    logic            w_halt_hit;

    if_id_t          w_if_id_d;
    if_id_t          w_if_id_q;
    logic            w_if_id_load;
    logic            w_if_id_flush;

    // Wraps modulo 2^32 by construction of the 32-bit add.
    assign w_pc_plus4          = r_pc + PC_STEP;
    assign w_redirect          = bus.redirect_valid;
    assign w_redirect_pc       = word_align(bus.redirect_target);
    assign w_target_misaligned = (bus.redirect_target[1:0] != 2'b00);
    assign w_halt_hit          = (bus.instruction == HALT_WORD);

    // IF/ID control: redirect flushes; in HALTED keep inserting bubbles;
    // in RUN load the fetched word unless stalled. A halt hit loads the
    // sentinel itself, which is exactly the fetched word.
    always_comb begin
        w_if_id_flush = w_redirect;
        w_if_id_load  = 1'b0;
        w_if_id_d     = '{instruction: bus.instruction, pcplus4: w_pc_plus4, valid: 1'b1};
        if (!w_redirect) begin
            if (r_state == ST_HALTED) begin
                w_if_id_load = 1'b1;
                w_if_id_d    = '{instruction: NOP_WORD, pcplus4: w_if_id_q.pcplus4, valid: 1'b0};
            end else if (!bus.stall) begin
                w_if_id_load = 1'b1;
            end
        end
    end

    instruction_fetch_unit_if_id_register #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id_register (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (w_if_id_flush),
        .i_load  (w_if_id_load),
        .i_d     (w_if_id_d),
        .o_q     (w_if_id_q)
    );

    // PC / fetch-state FSM. Redirect wins in any state and squashes a halt
    // that was entered speculatively past an unresolved branch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_halted     <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (w_redirect) begin
            r_state      <= ST_RUN;
            r_pc         <= w_redirect_pc;
            r_halted     <= 1'b0;
            r_misaligned <= r_misaligned | w_target_misaligned;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!bus.stall) begin
                        if (w_halt_hit) begin
                            // PC parks on the sentinel so a later redirect
                            // is the only way out.
                            r_state  <= ST_HALTED;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc <= w_pc_plus4;
                        end
                    end
                end
                ST_HALTED: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.address           = r_pc;
    assign bus.if_id_instruction = w_if_id_q.instruction;
    assign bus.if_id_pcplus4     = w_if_id_q.pcplus4;
    assign bus.if_id_valid       = w_if_id_q.valid;
    assign bus.halted            = r_halted;
    assign bus.misaligned        = r_misaligned;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-memory read interface. Owns the program counter, drives the word address into the combinational instruction memory, and captures the returned word into the IF/ID pipeline register together with PC+4. Supports stall, branch/jump redirect with flush, and a halt state entered on a sentinel instruction. Sits between the hazard/branch logic and the decode stage of the MIPS pipeline.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.
NOP_WORD, 32'h0000_0000, value placed in the IF/ID instruction field on flush or reset.

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  asynchronous, active-low reset (0 = reset asserted)
Stall  in  1  hold PC and IF/ID (load-use hazard)
RedirectValid  in  1  branch taken or jump resolved this cycle
RedirectTarget  in  32  new PC; bits [1:0] ignored
Instruction  in  32  word returned by instruction memory for Address (same cycle)
Address  out  32  current PC driven to instruction memory
IF_ID_Instruction  out  32  registered fetched word
IF_ID_PCPlus4  out  32  registered PC+4 of that word
IF_ID_Valid  out  1  IF/ID holds a real instruction
Halted  out  1  fetch stopped on HALT_WORD
Misaligned  out  1  sticky; set when RedirectTarget[1:0] != 0 on an accepted redirect

Behaviour:
- Reset (async, Reset=0): PC=RESET_PC, IF_ID_Instruction=NOP_WORD, IF_ID_PCPlus4=0, IF_ID_Valid=0, Halted=0, Misaligned=0, state=RUN. Outputs take reset values immediately, without waiting for a clock edge.
- Address = PC (combinational). Memory is combinational, so the word for PC is sampled at the same edge. Fetch-to-IF/ID latency is 1 clock.
- States: RUN, HALTED. Per-edge priority in RUN is Redirect > Stall > Halt detect > Normal.
- Redirect (RedirectValid=1, any state):
  - PC <= {RedirectTarget[31:2],2'b00}.
  - IF/ID flushed: Instruction=NOP_WORD, PCPlus4=0, Valid=0.
  - state <= RUN and Halted <= 0. A redirect from an older branch squashes a speculative halt.
  - Misaligned <= Misaligned | (RedirectTarget[1:0]!=0).
  - A redirect overrides Stall in the same cycle.
- Stall (no redirect): PC and all IF/ID fields hold. Halt is not detected while stalled.
- Halt detect (RUN, no stall, no redirect, Instruction==HALT_WORD):
  - IF/ID loads HALT_WORD with PCPlus4=PC+4 and Valid=1.
  - PC holds.
  - state <= HALTED, Halted <= 1.
- Normal (RUN): PC <= PC+4; IF_ID_Instruction <= Instruction; IF_ID_PCPlus4 <= PC+4; IF_ID_Valid <= 1.
- HALTED, no redirect: PC holds, IF_ID_Valid <= 0, IF_ID_Instruction <= NOP_WORD, Halted stays 1. Stall has no effect.
- Arithmetic: PC+4 is 32-bit modulo 2^32, so 32'hFFFF_FFFC wraps to 0. Memory indexes only Address[8:2] (128 words), so PC 0x200 aliases word 0. This is legal and not flagged.
- Reset mid-operation (including in HALTED or mid-stall) returns immediately to the reset values above.

Decomposition:
- Shared package: HALT_WORD and NOP_WORD constants, the fetch-state enum {RUN, HALTED}, and the IF/ID bundle layout (instruction, pcplus4, valid), which the decode stage reuses.
- One natural sub-module: if_id_register, holding the load/hold/flush register for the IF/ID bundle. The PC and FSM stay in the top.

Test Plan:
1. Reset release with memory[i]=i*3 and no stall/redirect. After edge 1, Address=4, IF_ID_Instruction=0, PCPlus4=4, Valid=1. After edge 3, Address=12, IF_ID_Instruction=6, PCPlus4=12.
2. Stall=1 for 2 cycles at PC=8: Address stays 8 and IF/ID stays {3,8,1}. After release, the next edge gives IF_ID_Instruction=6 and Address=12.
3. Redirect to 0x40 together with Stall=1. Next edge: Address=0x40, Valid=0, IF_ID_Instruction=0. The edge after: IF_ID_Instruction=48, PCPlus4=0x44.
4. memory[5]=HALT_WORD, free run. After PC=0x14 is fetched: IF/ID={FFFFFFFF,0x18,1}, Halted=1, Address stays 0x14. On later edges Valid=0. Redirect to 0 clears Halted and fetch resumes at 0.
5. Redirect target 0x1F3: Address=0x1F0 and Misaligned=1, which stays set through later aligned redirects until reset. Also force PC=0xFFFFFFFC and check the next Address=0.
6. Assert Reset=0 asynchronously mid-cycle while HALTED: all outputs return to reset values before the next clock edge, and PC=RESET_PC.
